mmio_uart_tx: RTL

Memory-mapped UART transmitter on the CPU data-memory port, alongside `ram`. It decodes its own address window from `mem_addr`, queues bytes written by the CPU in a small FIFO, and serialises them 8N1 on `tx` with a programmable baud divider. The CPU reads status through a combinational read port so firmware can poll before writing.

---
 rtl/mmio_uart_tx_pkg.sv | 18 +
 rtl/mmio_uart_tx_if.sv | 9 +
 rtl/uart_tx_fifo.sv | 38 +++
 rtl/mmio_uart_tx.sv | 113 +++++++++++
 4 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// mmio_uart_tx_pkg: register map, STATUS bit positions and FSM states; UART_TX_PARITY_EN adds the PARITY state
package mmio_uart_tx_pkg;
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_PAR   = 4;
`ifdef UART_TX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  localparam logic PAR_EN = 1'b0;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
endpackage

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: CPU data-memory port as seen by the UART (store strobe, address, data, read-back)
interface mmio_uart_tx_if;
  logic        wr_sig;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  modport master (output wr_sig, addr, wr_data, input rd_data);
  modport slave  (input wr_sig, addr, wr_data, output rd_data);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO, power-of-two depth, async active-low reset to empty; ignores push when full and pop when empty
module uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          wr, rd;
  assign full  = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout  = mem[rp];
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  // storage needs no reset: only entries below the count are ever read
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
  // pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO; define UART_TX_PARITY_EN for an even-parity bit
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic          clk,
  input  logic          reset_n,
  mmio_uart_tx_if.slave bus,
  output logic          tx
);
  logic        hit, wr_tx, push, pop, full, empty, tick, tx_n, ovf, last_bit;
  logic [1:0]  sel;
  logic [7:0]  dout, shreg;
  logic [15:0] baud, div, cnt;
  logic [2:0]  bit_idx;
  logic [31:0] status;
  logic        unused;
  state_t      state, state_n;
  assign unused = ^{bus.addr[1:0], bus.wr_data[31:16]};
  assign hit    = bus.addr[31:4] == BASE_ADDR[31:4];
  assign sel    = bus.addr[3:2];
  assign wr_tx  = bus.wr_sig && hit && sel == REG_TXDATA;
  assign push   = wr_tx && !full;
  assign tick   = cnt == div - 16'd1;
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset_n(reset_n), .push(push), .pop(pop),
    .din(bus.wr_data[7:0]), .dout(dout), .full(full), .empty(empty)
  );
  // STATUS word assembled from the live flags
  always_comb begin
    status = '0;
    status[ST_FULL]  = full;
    status[ST_EMPTY] = empty;
    status[ST_BUSY]  = state != IDLE;
    status[ST_OVF]   = ovf;
    status[ST_PAR]   = PAR_EN;
  end
  assign bus.rd_data = !hit ? '0 : sel == REG_STATUS ? status : sel == REG_BAUDDIV ? {16'b0, baud} : '0;
  // overflow is sticky until software clears it; a full-FIFO store is dropped even if a pop coincides
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ovf  <= 1'b0;
      baud <= DEFAULT_DIV;
    end else begin
      if (wr_tx && full) ovf <= 1'b1;
      else if (bus.wr_sig && hit && sel == REG_STATUS && bus.wr_data[ST_OVF]) ovf <= 1'b0;
      if (bus.wr_sig && hit && sel == REG_BAUDDIV) baud <= bus.wr_data[15:0];
    end
`ifdef UART_TX_PARITY_EN
  logic par;
  // even parity of the frame's byte, captured when it leaves the FIFO
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) par <= 1'b0;
    else if (pop) par <= ^dout;
  assign last_bit = state_n == PARITY ? par : 1'b1;
`else
  assign last_bit = 1'b1;
`endif
  // FSM state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  // next state, pop request and the next serial level; the end of STOP chains straight into the next START
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        state_n = START;
      end
      START: if (tick) state_n = DATA;
`ifdef UART_TX_PARITY_EN
      DATA: if (tick && bit_idx == 3'd7) state_n = PARITY;
      PARITY: if (tick) state_n = STOP;
`else
      DATA: if (tick && bit_idx == 3'd7) state_n = STOP;
`endif
      STOP: if (tick) begin
        pop     = !empty;
        state_n = empty ? IDLE : START;
      end
      default: state_n = IDLE;
    endcase
    tx_n = pop ? 1'b0 : !tick || state == IDLE ? tx : state_n == DATA ? (state == START ? shreg[0] : shreg[1]) : last_bit;
  end
  // shifter, bit-cell counter and latched divider; tx is registered so it falls on the pop edge
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      tx      <= 1'b1;
      shreg   <= '0;
      div     <= 16'd1;
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      tx <= tx_n;
      if (pop) begin
        shreg   <= dout;
        div     <= baud == 16'd0 ? 16'd1 : baud;
        cnt     <= '0;
        bit_idx <= '0;
      end else if (state != IDLE) begin
        cnt <= tick ? '0 : cnt + 16'd1;
        if (tick && state == DATA) begin
          shreg   <= shreg >> 1;
          bit_idx <= bit_idx + 3'd1;
        end
      end
    end
endmodule
